// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router: pops one packet at a time from the source FIFOs
// and delivers it to one destination terminal, or to all but the source on broadcast.
module bus_rr_arbiter #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic                            busy,
  output logic                            err,
  output logic [7:0]                      drop_cnt
);

  localparam int unsigned idx_w = $clog2(drvrs);
  typedef logic [idx_w-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  idx_t               grant_q, grant_d;
  idx_t               last_grant_q, last_grant_d;
  logic [pckg_sz-1:0] hold_q, hold_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               rr_found;
  idx_t               rr_idx;
  logic [31:0]        cand;
  idx_t               cand_idx;
  logic [drvrs-1:0]   grant_oh;
  logic [drvrs-1:0]   dest_oh;
  logic [drvrs-1:0]   deliver_mask;
  logic [7:0]         dest;
  logic               is_bcast;
  logic               dest_valid;
  logic               drop;

  // Round-robin search: first pending source after the last grant, with wrap.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= drvrs; off++) begin
      cand     = (32'(last_grant_q) + off) % drvrs;
      cand_idx = idx_t'(cand);
      if (!rr_found && pndng[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    dest       = hold_q[pckg_sz-1 -: 8];
    is_bcast   = (dest == broadcast);
    dest_valid = (32'(dest) < drvrs) && (dest != 8'(grant_q));
    grant_oh   = '0;
    dest_oh    = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      grant_oh[i] = (idx_t'(i) == grant_q);
      dest_oh[i]  = (8'(i) == dest);
    end
    if (is_bcast)        deliver_mask = ~grant_oh;
    else if (dest_valid) deliver_mask = dest_oh;
    else                 deliver_mask = '0;
    drop = !is_bcast && !dest_valid;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d      = rr_idx;
          last_grant_d = rr_idx;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        // A source that withdrew its request is not delivered; just rearbitrate.
        if (pndng[grant_q]) begin
          hold_d  = D_pop[grant_q];
          state_d = DELIVER;
        end else begin
          state_d = IDLE;
        end
      end
      DELIVER: begin
        state_d = IDLE;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= idx_t'(drvrs - 1);
      hold_q       <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Outputs depend only on registered state, grant and hold.
  always_comb begin
    pop      = (state_q == CAPTURE) ? grant_oh : '0;
    push     = (state_q == DELIVER) ? deliver_mask : '0;
    err      = (state_q == DELIVER) && drop;
    busy     = (state_q != IDLE);
    drop_cnt = drop_cnt_q;
    for (int unsigned i = 0; i < drvrs; i++) D_push[i] = hold_q;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter and router for the shared packet bus under verification. It pulls one packet at a time from the per-driver input FIFOs and decodes the destination byte. It then delivers the packet to one destination terminal, or to every terminal except the source when the packet is a broadcast. Its push/D_push outputs are what the monitors sample, so it sits directly upstream of the monitor → checker path and produces the traffic the checker compares against driver stimulus.

## Interface
- drvrs, 4: number of bus terminals (sources and destinations); 2..255.
- pckg_sz, 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID, bits [pckg_sz-9:0] hold the payload; pckg_sz > 8.
- broadcast, 8'hFF: destination ID meaning "all terminals except the source".

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- pndng  in  [drvrs-1:0]  source FIFO i is non-empty.
- D_pop  in  [drvrs-1:0][pckg_sz-1:0]  head word of source FIFO i; valid while pndng[i].
- pop  out  [drvrs-1:0]  one-hot, one-cycle strobe that removes the head of the granted FIFO.
- push  out  [drvrs-1:0]  one-cycle delivery strobe per destination.
- D_push  out  [drvrs-1:0][pckg_sz-1:0]  delivered word; all lanes carry the held packet; qualified by push[i].
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when a packet is dropped.
- drop_cnt  out  8  count of dropped packets; saturates at 8'hFF.

## Operation
- State machine: IDLE → CAPTURE → DELIVER → IDLE.
- IDLE: if pndng != 0, select the first set bit searching from (last_grant+1) mod drvrs upward with wrap. Register it as grant and last_grant, then go to CAPTURE. If pndng == 0, stay in IDLE.
- CAPTURE: assert pop[grant] and latch hold <= D_pop[grant]. Go to DELIVER.
- DELIVER: dest = hold[pckg_sz-1:pckg_sz-8].
  - dest == broadcast: push = all ones except bit grant.
  - dest < drvrs and dest != grant: push = one-hot at dest.
  - Otherwise (out-of-range dest, or dest == grant): push = 0, pulse err, drop_cnt++ (saturating).
  - In every case, go to IDLE.
- Outputs are decoded only from registered state, grant and hold. There is no combinational path from pndng or D_pop to any output.
- pndng deasserting between IDLE and CAPTURE is a protocol violation by the source. Behaviour in that case is not required beyond no hang: return to IDLE.

## Timing
- Reset values: state = IDLE, last_grant = drvrs-1 (so driver 0 has first priority), grant = 0, hold = 0, pop = 0, push = 0, D_push = 0, busy = 0, err = 0, drop_cnt = 0.
- Latency:
  - pndng seen high at edge N → pop in cycle N+1 → push in cycle N+2.
  - Back in IDLE at edge N+3.
  - The next grant is possible at edge N+3, so the next pop is in cycle N+4.
- Throughput: one packet per 3 cycles with continuous pending traffic.
- Fairness: with all sources pending, grants follow the order 0,1,2,3,0,…; no source waits more than drvrs packets.
- Simultaneous requests are resolved only by the round-robin pointer. New pndng bits that arrive during CAPTURE or DELIVER are considered at the next IDLE.
- Reset mid-operation: returns to IDLE on the next edge and no push is issued. A packet already popped in CAPTURE is lost; the verification environment treats this as expected.
- drop_cnt at 8'hFF stays 8'hFF; err still pulses.

## Test plan
- Reset, then driver 0 pending with 16'h01_AB → pop = 4'b0001 at cycle +1; push = 4'b0010 with D_push[1] = 16'h01AB at cycle +2; busy high for 2 cycles.
- Drivers 0, 1 and 2 pending simultaneously with 16'h02_CC, 16'h00_DA and 16'h03_11 → grants in the order 0, 1, 2. Deliveries:
  - push[2] = 16'h02CC
  - push[0] = 16'h00DA
  - push[3] = 16'h0311
  - pop pulses 3 cycles apart.
- Driver 2 sends 16'hFF_55 → push = 4'b1011, all lanes 16'hFF55, pop[2] only.
- Driver 1 sends 16'h01_77 (self) and then 16'h09_00 (out of range) → no push; err pulses twice; drop_cnt = 2.
- Assert reset during CAPTURE of 16'h03_AA from driver 0 → no push ever appears for it; outputs at reset values; next grant goes to driver 0.
- 256 invalid packets → drop_cnt saturates at 8'hFF and does not wrap.
